// File: rtl/truth_table_scanner.sv
// -----------------------------------------------------------------------------
// truth_table_scanner
//
// Walks a downstream 4-input combinational block through all 16 input vectors.
// For each vector it holds the inputs for SETTLE_CYCLES cycles, samples F for
// one cycle, and builds a 16-bit truth table plus a count of ones.
//
// Ports
//   clk          single clock, rising-edge
//   rst_n        asynchronous active-low reset
//   start        request a full sweep (accepted only in IDLE, abort has priority)
//   abort        cancel a sweep in progress
//   A,B,C,D      registered stimulus to the downstream function (A is the MSB)
//   F            function output returned from the downstream block
//   busy         high in DRIVE and SAMPLE
//   done         one-cycle pulse when a sweep completes
//   table_valid  table_out holds a complete sweep
//   table_out    bit i = F for {A,B,C,D} = i
//   ones_count   number of vectors with F = 1 (0..16)
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for start; stimulus at 0, results held
// DRIVE  | stimulus = index, counting SETTLE_CYCLES cycles of settling
// SAMPLE | capture F into table_out[index], advance or finish
// DONE   | sweep complete; done/table_valid raised on the exit edge
// -----------------------------------------------------------------------------
module truth_table_scanner #(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic        F,
    output logic        A,
    output logic        B,
    output logic        C,
    output logic        D,
    output logic        busy,
    output logic        done,
    output logic        table_valid,
    output logic [15:0] table_out,
    output logic [4:0]  ones_count
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DRIVE  = 2'd1,
        S_SAMPLE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    state_t      r_state;
    logic [3:0]  r_index;
    logic [3:0]  r_settle;
    logic [3:0]  r_abcd;
    logic        r_busy;
    logic        r_done;
    logic        r_valid;
    logic [15:0] r_table;
    logic [4:0]  r_ones;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_index  <= 4'd0;
            r_settle <= 4'd0;
            r_abcd   <= 4'd0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_valid  <= 1'b0;
            r_table  <= 16'h0000;
            r_ones   <= 5'd0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // abort outranks start so a simultaneous request never launches
                    if (start && !abort) begin
                        r_state  <= S_DRIVE;
                        r_index  <= 4'd0;
                        r_settle <= 4'd0;
                        r_abcd   <= 4'd0;
                        r_busy   <= 1'b1;
                        r_valid  <= 1'b0;
                        r_table  <= 16'h0000;
                        r_ones   <= 5'd0;
                    end
                end
                S_DRIVE: begin
                    if (abort) begin
                        r_state <= S_IDLE;
                        r_abcd  <= 4'd0;
                        r_busy  <= 1'b0;
                    end else if (r_settle == SETTLE_LAST) begin
                        r_state <= S_SAMPLE;
                    end else begin
                        r_settle <= r_settle + 4'd1;
                    end
                end
                S_SAMPLE: begin
                    if (abort) begin
                        r_state <= S_IDLE;
                        r_abcd  <= 4'd0;
                        r_busy  <= 1'b0;
                    end else begin
                        r_table[r_index] <= F;
                        r_ones           <= r_ones + {4'd0, F};
                        if (r_index == 4'd15) begin
                            r_state <= S_DONE;
                            r_abcd  <= 4'd0;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state  <= S_DRIVE;
                            r_index  <= r_index + 4'd1;
                            r_abcd   <= r_index + 4'd1;
                            r_settle <= 4'd0;
                        end
                    end
                end
                S_DONE: begin
                    // done is registered on the exit edge, so the pulse lands one
                    // cycle after DONE is entered
                    r_state <= S_IDLE;
                    r_done  <= 1'b1;
                    r_valid <= 1'b1;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign {A, B, C, D} = r_abcd;
    assign busy         = r_busy;
    assign done         = r_done;
    assign table_valid  = r_valid;
    assign table_out    = r_table;
    assign ones_count   = r_ones;

endmodule

// File: tb/tb_truth_table_scanner.sv
module tb_truth_table_scanner;

    localparam int S1 = 1;
    localparam int S3 = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start1 = 1'b0, abort1 = 1'b0, start3 = 1'b0, abort3 = 1'b0;
    logic a1, b1, c1, d1, busy1, done1, tv1, f1;
    logic a3, b3, c3, d3, busy3, done3, tv3, f3;
    logic [15:0] to1, to3;
    logic [4:0]  oc1, oc3;

    int          kind1 = 0, kind3 = 0;
    logic [15:0] rnd1 = 16'h0, rnd3 = 16'h0;

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] tbl;
        logic [4:0]  ones;
        int          cycle;
    } exp_t;

    exp_t q1[$];
    exp_t q3[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Downstream function: 0 A&B, 1 A^B^C^D, 2 const 1, 3 const 0, 4 random table
    function automatic logic eval_f(int kind, logic [15:0] rnd, logic [3:0] v);
        case (kind)
            0:       return v[3] & v[2];
            1:       return ^v;
            2:       return 1'b1;
            3:       return 1'b0;
            default: return rnd[v];
        endcase
    endfunction

    always_comb f1 = eval_f(kind1, rnd1, {a1, b1, c1, d1});
    always_comb f3 = eval_f(kind3, rnd3, {a3, b3, c3, d3});

    // Reference: truth table computed arithmetically from the function rules
    function automatic logic [15:0] ref_table(int kind, logic [15:0] rnd);
        logic [15:0] t;
        int a, b, c, d;
        t = 16'h0;
        for (int i = 0; i < 16; i++) begin
            a = (i >> 3) & 1; b = (i >> 2) & 1; c = (i >> 1) & 1; d = i & 1;
            case (kind)
                0:       t[i] = ((a * b) == 1);
                1:       t[i] = (((a + b + c + d) % 2) == 1);
                2:       t[i] = 1'b1;
                3:       t[i] = 1'b0;
                default: t[i] = rnd[i];
            endcase
        end
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    truth_table_scanner #(.SETTLE_CYCLES(S1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1), .F(f1),
        .A(a1), .B(b1), .C(c1), .D(d1), .busy(busy1), .done(done1),
        .table_valid(tv1), .table_out(to1), .ones_count(oc1)
    );

    truth_table_scanner #(.SETTLE_CYCLES(S3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .abort(abort3), .F(f3),
        .A(a3), .B(b3), .C(c3), .D(d3), .busy(busy3), .done(done3),
        .table_valid(tv3), .table_out(to3), .ones_count(oc3)
    );

    // Monitor: pops an expectation whenever a done pulse appears
    always @(negedge clk) begin : mon
        exp_t e;
        if (rst_n) begin
            if (done1) begin
                if (q1.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL dut1 unexpected done: got 1 expected 0 (t=%0t)", $time);
                end else begin
                    e = q1.pop_front();
                    chk("dut1 table_out", 32'(to1), 32'(e.tbl));
                    chk("dut1 ones_count", 32'(oc1), 32'(e.ones));
                    chk("dut1 table_valid", 32'(tv1), 32'd1);
                    chk("dut1 done cycle", 32'(cyc), 32'(e.cycle));
                end
            end
            if (done3) begin
                if (q3.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL dut3 unexpected done: got 1 expected 0 (t=%0t)", $time);
                end else begin
                    e = q3.pop_front();
                    chk("dut3 table_out", 32'(to3), 32'(e.tbl));
                    chk("dut3 ones_count", 32'(oc3), 32'(e.ones));
                    chk("dut3 table_valid", 32'(tv3), 32'd1);
                    chk("dut3 done cycle", 32'(cyc), 32'(e.cycle));
                end
            end
            if (!busy1) chk("dut1 idle stimulus", 32'({a1, b1, c1, d1}), 32'd0);
            if (!busy3) chk("dut3 idle stimulus", 32'({a3, b3, c3, d3}), 32'd0);
        end
    end

    task automatic wait_q1();
        for (int i = 0; i < 200 && q1.size() != 0; i++) @(negedge clk);
        if (q1.size() != 0) begin
            checks++; errors++;
            $display("FAIL dut1 sweep timeout: got no done expected done");
            q1.delete();
        end
        @(negedge clk);
    endtask

    task automatic wait_q3();
        for (int i = 0; i < 300 && q3.size() != 0; i++) @(negedge clk);
        if (q3.size() != 0) begin
            checks++; errors++;
            $display("FAIL dut3 sweep timeout: got no done expected done");
            q3.delete();
        end
        @(negedge clk);
    endtask

    task automatic sweep1(input int kind);
        exp_t e;
        kind1 = kind;
        @(negedge clk);
        e.tbl   = ref_table(kind, rnd1);
        e.ones  = 5'($countones(e.tbl));
        e.cycle = cyc + 1 + 16 * (S1 + 1) + 1;
        q1.push_back(e);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        chk("dut1 busy after start", 32'(busy1), 32'd1);
        wait_q1();
    endtask

    task automatic sweep3(input int kind);
        exp_t e;
        kind3 = kind;
        @(negedge clk);
        e.tbl   = ref_table(kind, rnd3);
        e.ones  = 5'($countones(e.tbl));
        e.cycle = cyc + 1 + 16 * (S3 + 1) + 1;
        q3.push_back(e);
        start3 = 1'b1;
        @(negedge clk);
        start3 = 1'b0;
        // stray start pulses while busy must not restart or extend the sweep
        for (int i = 0; i < 60; i++) begin
            start3 = (i % 13 == 5);
            @(negedge clk);
        end
        start3 = 1'b0;
        wait_q3();
    endtask

    initial begin : stim
        logic [15:0] part;
        bit          seen;

        #1;
        chk("reset table_out", 32'(to1), 32'd0);
        chk("reset ones_count", 32'(oc1), 32'd0);
        chk("reset outputs", 32'({a1, b1, c1, d1, busy1, done1, tv1}), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        sweep1(0);
        chk("and table", 32'(to1), 32'hF000);
        chk("and ones", 32'(oc1), 32'd4);
        chk("and valid", 32'(tv1), 32'd1);
        sweep1(1);
        chk("xor table", 32'(to1), 32'h6996);
        chk("xor ones", 32'(oc1), 32'd8);
        sweep1(2);
        chk("one table", 32'(to1), 32'hFFFF);
        chk("one ones", 32'(oc1), 32'd16);
        sweep1(3);
        chk("zero table", 32'(to1), 32'h0000);
        chk("zero ones", 32'(oc1), 32'd0);
        for (int k = 0; k < 4; k++) begin
            rnd1 = 16'($urandom);
            sweep1(4);
        end

        // abort while index 7 is being driven
        kind1 = 1;
        @(negedge clk);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            if ({a1, b1, c1, d1} == 4'd7) seen = 1'b1;
            else @(negedge clk);
        end
        chk("reached index 7", 32'(seen), 32'd1);
        abort1 = 1'b1;
        @(negedge clk);
        abort1 = 1'b0;
        part = ref_table(1, 16'h0) & 16'h007F;
        chk("abort busy", 32'(busy1), 32'd0);
        chk("abort valid", 32'(tv1), 32'd0);
        chk("abort partial table", 32'(to1), 32'(part));
        chk("abort partial ones", 32'(oc1), 32'($countones(part)));
        repeat (5) @(negedge clk);
        chk("abort held table", 32'(to1), 32'(part));
        sweep1(1);

        // start and abort together in IDLE: no sweep, results held
        start1 = 1'b1;
        abort1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        abort1 = 1'b0;
        chk("start+abort busy", 32'(busy1), 32'd0);
        repeat (2) @(negedge clk);
        chk("start+abort valid held", 32'(tv1), 32'd1);
        chk("start+abort table held", 32'(to1), 32'h6996);

        // slower settle instance with stray start pulses
        rnd3 = 16'($urandom);
        sweep3(4);
        sweep3(0);
        chk("dut3 and table", 32'(to3), 32'hF000);

        // asynchronous reset mid-sweep
        kind1 = 2;
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async rst table", 32'(to1), 32'd0);
        chk("async rst ones", 32'(oc1), 32'd0);
        chk("async rst outputs", 32'({a1, b1, c1, d1, busy1, done1, tv1}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        rnd1 = 16'($urandom);
        sweep1(4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/truth_table_scanner.md
TRUTH_TABLE_SCANNER -- requirements
Module: truth_table_scanner

Interface
REQ-001 SETTLE_CYCLES, default 1: cycles each input vector is held before F is sampled; legal range 1..15.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 start  input  1  request a full 16-vector sweep; honoured only in IDLE.
REQ-005 abort  input  1  cancel a sweep in progress.
REQ-006 A, B, C, D  output  1 each  stimulus to the downstream 4-input combinational function.
REQ-007 F  input  1  function output returned from the downstream block.
REQ-008 busy  output  1  high while a sweep is in progress (DRIVE or SAMPLE).
REQ-009 done  output  1  one-cycle pulse when a sweep completes.
REQ-010 table_valid  output  1  high when table_out holds a complete sweep.
REQ-011 table_out  output  16  captured truth table; bit i = F for {A,B,C,D} = i (A is the MSB).
REQ-012 ones_count  output  5  number of vectors for which F = 1 (0..16).

Function
REQ-013 FSM states SHALL be IDLE, DRIVE, SAMPLE and DONE, held in a registered state variable.
REQ-014 IDLE with start = 1 SHALL on that edge:
- go to DRIVE;
- set index = 0 and settle counter = 0;
- clear table_out, ones_count and table_valid.
REQ-015 In DRIVE, {A,B,C,D} SHALL equal index, registered, with no glitch between vectors.
REQ-016 DRIVE SHALL last exactly SETTLE_CYCLES cycles, then go to SAMPLE.
REQ-017 SAMPLE SHALL last one cycle and capture F into table_out[index] and add F to ones_count.
- {A,B,C,D} stays at index during SAMPLE.
REQ-018 SAMPLE with index < 15 SHALL increment index, clear the settle counter and return to DRIVE.
REQ-019 SAMPLE with index = 15 SHALL go to DONE; index SHALL NOT wrap.
REQ-020 DONE SHALL last one cycle with done = 1 and table_valid set, then go to IDLE.
REQ-021 Timing: if start is sampled at edge 0, done SHALL be high in the cycle after edge 16*(SETTLE_CYCLES+1)+1 (33 for the default).
REQ-022 busy SHALL be 1 exactly in DRIVE and SAMPLE.
REQ-023 start while busy or in DONE SHALL be ignored; it does not restart or extend the sweep.
REQ-024 abort = 1 in DRIVE or SAMPLE SHALL:
- return to IDLE on the next edge;
- leave table_valid = 0 and not pulse done;
- drive {A,B,C,D} = 0;
- leave partial table_out and ones_count as is.
REQ-025 If abort and start are both high in IDLE, abort SHALL win and the sweep SHALL NOT start.
REQ-026 In IDLE, table_out, ones_count and table_valid SHALL hold their values until the next accepted start.
REQ-027 In IDLE and DONE, {A,B,C,D} SHALL be 0.
REQ-028 ones_count SHALL be 5 bits wide so that 16 does not overflow.

Reset
REQ-029 rst_n = 0 SHALL immediately, independent of clk:
- force IDLE;
- set A = B = C = D = 0, busy = 0, done = 0, table_valid = 0, table_out = 16'h0000, ones_count = 0;
- clear index and the settle counter.
REQ-030 Reset asserted mid-sweep SHALL discard the sweep; start SHALL be honoured on the first edge after rst_n deasserts.

Verification
REQ-031 F = A&B, default SETTLE_CYCLES, pulse start -> done at cycle 33, table_out = 16'hF000, ones_count = 4, table_valid = 1.
REQ-032 F = A^B^C^D -> table_out = 16'h6996, ones_count = 8.
REQ-033 F tied to 1 and then to 0 -> 16'hFFFF / 16, then 16'h0000 / 0.
REQ-034 SETTLE_CYCLES = 3 -> each vector held 3 cycles before its sample; done at cycle 65; start pulses mid-sweep have no effect.
REQ-035 abort asserted during index 7 -> IDLE on the next edge, no done pulse, table_valid = 0; a following start gives a correct complete table.
REQ-036 rst_n asserted asynchronously mid-sweep -> all outputs reach their reset values before the next clk edge.
